// File: rtl/delay_meter.sv
// Measures the cycle latency from a rising edge on ref_in to the matching rising
// edge on dly_in, reporting a held result with a one-cycle valid or timeout pulse.
module delay_meter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] max_delay,
  input  logic                 ref_in,
  input  logic                 dly_in,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] delay,
  output logic                 delay_valid,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] limit;
  logic [CNT_WIDTH-1:0] n;
  logic                 ref_q;
  logic                 dly_q;
  logic                 ref_rise;
  logic                 dly_rise;

  assign ref_rise = ref_in & ~ref_q;
  assign dly_rise = dly_in & ~dly_q;
  // A zero limit selects the longest representable wait.
  assign limit    = (max_delay == '0) ? '1 : max_delay;
  assign n        = cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      delay       <= '0;
      delay_valid <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      ref_q       <= 1'b0;
      dly_q       <= 1'b0;
    end else begin
      ref_q       <= ref_in;
      dly_q       <= dly_in;
      delay_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (ref_rise && dly_rise) begin
            delay       <= '0;
            delay_valid <= 1'b1;
            state       <= continuous ? ARMED : IDLE;
            busy        <= continuous;
          end else if (ref_rise) begin
            cnt   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          // Result and timeout both end the measurement on the deciding edge.
          if (dly_rise) begin
            delay       <= n;
            delay_valid <= 1'b1;
            state       <= continuous ? ARMED : IDLE;
            busy        <= continuous;
          end else if (n == limit) begin
            timeout <= 1'b1;
            state   <= continuous ? ARMED : IDLE;
            busy    <= continuous;
          end else begin
            cnt <= n;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
